if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC, drives the synchronous instruction SRAM, produces `if_to_id_bus` for the decode stage and applies `br_bus` redirects coming back from decode. It also delivers the instruction word aligned with the PC held in decode, using a hold buffer so stalls and bubbles never present a stale or wrong SRAM word to decode.

## Interface
- `RESET_PC`, 32'hbfc0_0000: PC of the first fetched instruction.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high; clock clk.
- `stall` in 6 (`StallBus`): pipeline stall vector.
  - Bit 0 = IF, bit 1 = IF→ID, bit 2 = ID→EX.
  - `Stop`=1, `NoStop`=0.
- `br_bus` in 33 (`BR_WD`): {br_e, br_addr[31:0]} from decode; combinational in the same cycle.
- `inst_sram_rdata` in 32: SRAM read data, valid one cycle after the address.
- `if_to_id_bus` out 33 (`IF_TO_ID_WD`): {ce, pc[31:0]}.
- `inst_sram_en` out 1: SRAM enable.
- `inst_sram_wen` out 4: constant 4'b0.
- `inst_sram_addr` out 32: fetch address.
- `inst_sram_wdata` out 32: constant 32'b0.
- `inst_to_id` out 32: instruction for the PC currently registered in decode.

## Operation
- Registers:
  - `pc_reg` (reset `RESET_PC`-4 = 32'hbfbf_fffc).
  - `ce_reg` (reset 0).
  - `hold_reg` (reset 0).
  - 2-bit `dstate` (reset BUBBLE).
- `next_pc` = br_e ? br_addr : pc_reg + 32'h4. Adder wraps modulo 2^32 with no carry-out.
- When stall[0]==NoStop: pc_reg <= next_pc, ce_reg <= 1. Otherwise both hold.
  - A branch asserted while IF is stalled is not latched. Decode re-presents it until it advances.
- `if_to_id_bus` = {ce_reg, pc_reg}.
- `inst_sram_en` = ce_reg and `inst_sram_addr` = pc_reg, driven every cycle including stall cycles.
- Delay slot: when br_e is high, the word at pc_reg (the delay slot) still enters decode. No flush.
- The stall vector is prefix-form (stall[k]=Stop implies stall[j]=Stop for j<k). Other vectors are illegal and unchecked.
- `dstate` transitions, evaluated at every posedge:
  - stall[1]==NoStop → LIVE, whatever the current state.
  - stall[1]==Stop and stall[2]==NoStop → BUBBLE. Decode is zeroed by its own logic.
  - stall[1]==Stop and stall[2]==Stop:
    - From LIVE → HELD, with hold_reg <= inst_sram_rdata.
    - From HELD → HELD; hold_reg unchanged.
    - From BUBBLE → BUBBLE.
- `inst_to_id` output mux:
  - LIVE → inst_sram_rdata.
  - HELD → hold_reg.
  - BUBBLE → 32'b0.
- Encoding: BUBBLE=2'd0, LIVE=2'd1, HELD=2'd2. Value 2'd3 is unreachable and decodes as BUBBLE.

## Timing
- Reset, in the cycle after rst is sampled high:
  - if_to_id_bus = {1'b0, 32'hbfbf_fffc}.
  - inst_sram_en = 0.
  - inst_to_id = 0.
  - dstate = BUBBLE.
- First fetch, first non-reset edge (stall[0]=NoStop):
  - pc_reg = 32'hbfc0_0000, ce = 1, inst_sram_en = 1.
  - The word is presented on inst_to_id one cycle later, when decode has latched this PC and dstate = LIVE.
- Branch redirect latency:
  - br_e is sampled in cycle t; IF fetches br_addr in t+1.
  - Decode holds the delay slot in t+1 and the target in t+2.
- HELD capture takes effect at the first stall edge. The word decode was using in that cycle stays on inst_to_id for the whole stall, however long.
- Release: at the edge where stall[1] returns NoStop, decode latches the pending pc_reg. The SRAM word for it arrives in the next cycle (LIVE). Nothing is lost and nothing is duplicated.
- Reset mid-stall: rst overrides everything.
  - pc_reg = 32'hbfbf_fffc, hold_reg = 0, dstate = BUBBLE.
  - Fetch restarts at RESET_PC.
- No combinational path from `stall` to `inst_to_id`.
- br_bus → inst_sram_addr is registered (via pc_reg), so there is no combinational loop through decode.

## Test plan
- Reset then free run, SRAM returns word = address:
  - After release, inst_sram_addr goes bfc00000, bfc00004, bfc00008 on consecutive cycles.
  - inst_to_id follows each address one cycle later.
  - ce rises one cycle after reset release.
- Branch with delay slot: decode asserts br_e, br_addr=32'hbfc0_0100 while pc_reg=bfc00008.
  - Next inst_sram_addr = bfc00100.
  - Decode receives bfc00008 then bfc00100.
- ID stall of 3 cycles (stall=6'b000111) while decode holds bfc00004 and IF holds bfc00008:
  - inst_to_id stays 32'hbfc0_0004 for all 3 cycles.
  - On release, decode gets bfc00008 with matching data.
- Bubble insertion (stall=6'b000011 for 1 cycle):
  - inst_to_id = 0 that cycle.
  - pc_reg holds.
  - Then LIVE resumes with the held PC.
- Reset asserted during HELD:
  - Next cycle: inst_to_id=0, if_to_id_bus={0, bfbffffc}, hold_reg=0.
  - Fetch restarts at bfc00000.
- PC wrap: force br_addr=32'hffff_fffc.
  - Following fetch address = 32'h0000_0000 with no error indication.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: pipeline control in, SRAM port and decode-side outputs.
// The master side (if_fetch) drives the SRAM request and the decode outputs.
interface if_fetch_if;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [31:0] inst_sram_rdata;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_to_id;

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output if_to_id_bus, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata, inst_to_id
    );

    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata, inst_to_id
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: PC register, SRAM request, branch redirect and a
// decode-aligned instruction output that survives stalls and bubbles.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus
);
    localparam logic STOP = 1'b1;

    // What decode is currently looking at, from the fetch stage's view.
    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        LIVE   = 2'd1,
        HELD   = 2'd2
    } dstate_t;

    logic [31:0] pc_reg;
    logic        ce_reg;
    logic [31:0] hold_reg;
    dstate_t     dstate, dstate_nxt;
    logic        hold_en;

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;

    // Stall bits above ID->EX do not affect fetch.
    logic unused_stall;
    assign unused_stall = ^bus.stall[5:3];

    assign br_e    = bus.br_bus[32];
    assign br_addr = bus.br_bus[31:0];
    // Sequential PC wraps silently at 2^32.
    assign next_pc = br_e ? br_addr : pc_reg + 32'h4;

    // PC / fetch-enable register; a branch seen while IF is stalled is
    // dropped here and re-presented by decode until it advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC - 32'h4;
            ce_reg <= 1'b0;
        end else if (bus.stall[0] != STOP) begin
            pc_reg <= next_pc;
            ce_reg <= 1'b1;
        end
    end

    // Decode-state register and hold buffer capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            dstate   <= BUBBLE;
            hold_reg <= 32'h0;
        end else begin
            dstate <= dstate_nxt;
            if (hold_en)
                hold_reg <= bus.inst_sram_rdata;
        end
    end

    // Next decode state: advance -> LIVE, bubble -> BUBBLE, full stall
    // freezes the word decode was using (captured once on LIVE->HELD).
    always_comb begin
        dstate_nxt = dstate;
        hold_en    = 1'b0;
        if (bus.stall[1] != STOP) begin
            dstate_nxt = LIVE;
        end else if (bus.stall[2] != STOP) begin
            dstate_nxt = BUBBLE;
        end else begin
            case (dstate)
                LIVE: begin
                    dstate_nxt = HELD;
                    hold_en    = 1'b1;
                end
                HELD:    dstate_nxt = HELD;
                default: dstate_nxt = BUBBLE;
            endcase
        end
    end

    // Instruction mux toward decode; depends on registered state only.
    always_comb begin
        bus.inst_to_id = 32'h0;
        case (dstate)
            LIVE:    bus.inst_to_id = bus.inst_sram_rdata;
            HELD:    bus.inst_to_id = hold_reg;
            default: bus.inst_to_id = 32'h0;
        endcase
    end

    assign bus.if_to_id_bus    = {ce_reg, pc_reg};
    assign bus.inst_sram_en    = ce_reg;
    assign bus.inst_sram_wen   = 4'b0;
    assign bus.inst_sram_addr  = pc_reg;
    assign bus.inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: SRAM model returns word == address, so the
// expected instruction for each cycle is the PC decode should hold.
module tb_if_fetch;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    if_fetch_if bus ();

    if_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: data one cycle after an enabled address.
    logic [31:0] sram_q;
    initial sram_q = 32'h0;
    always_ff @(posedge clk) begin
        if (bus.inst_sram_en === 1'b1)
            sram_q <= bus.inst_sram_addr;
    end
    assign bus.inst_sram_rdata = sram_q;

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        br_e;
        logic [31:0] br_addr;
        logic [31:0] exp_pc;
        logic        exp_ce;
        logic        chk_inst;
        logic [31:0] exp_inst;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba);
        @(negedge clk);
        rst        = r;
        bus.stall  = s;
        bus.br_bus = {be, ba};
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int idx, input logic [31:0] pc, input logic ce,
                              input logic ci, input logic [31:0] inst);
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, " addr"}, bus.inst_sram_addr, pc);
        check({tag, " id_pc"}, bus.if_to_id_bus[31:0], pc);
        check({tag, " ce"}, {31'h0, bus.if_to_id_bus[32]}, {31'h0, ce});
        check({tag, " en"}, {31'h0, bus.inst_sram_en}, {31'h0, ce});
        if (ci)
            check({tag, " inst"}, bus.inst_to_id, inst);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        bus.stall  = 6'b0;
        bus.br_bus = 33'h0;

        //           rst stall     br  br_addr       exp_pc        ce chk inst
        vecs[0]  = '{1'b1, 6'b000000, 1'b0, 32'h0,         32'hbfbf_fffc, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 6'b000000, 1'b0, 32'h0,         32'hbfbf_fffc, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'hbfc0_0000, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'hbfc0_0004, 1'b1, 1'b1, 32'hbfc0_0000};
        vecs[4]  = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'hbfc0_0008, 1'b1, 1'b1, 32'hbfc0_0004};
        // branch at pc bfc00008: delay slot then target
        vecs[5]  = '{1'b0, 6'b000000, 1'b1, 32'hbfc0_0100, 32'hbfc0_0100, 1'b1, 1'b1, 32'hbfc0_0008};
        vecs[6]  = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'hbfc0_0104, 1'b1, 1'b1, 32'hbfc0_0100};
        // 3-cycle ID stall: decode keeps bfc00100
        vecs[7]  = '{1'b0, 6'b000111, 1'b0, 32'h0,         32'hbfc0_0104, 1'b1, 1'b1, 32'hbfc0_0100};
        vecs[8]  = '{1'b0, 6'b000111, 1'b1, 32'h1234_0000, 32'hbfc0_0104, 1'b1, 1'b1, 32'hbfc0_0100};
        vecs[9]  = '{1'b0, 6'b000111, 1'b0, 32'h0,         32'hbfc0_0104, 1'b1, 1'b1, 32'hbfc0_0100};
        vecs[10] = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'hbfc0_0108, 1'b1, 1'b1, 32'hbfc0_0104};
        // one-cycle bubble
        vecs[11] = '{1'b0, 6'b000011, 1'b0, 32'h0,         32'hbfc0_0108, 1'b1, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'hbfc0_010c, 1'b1, 1'b1, 32'hbfc0_0108};
        // PC wrap
        vecs[13] = '{1'b0, 6'b000000, 1'b1, 32'hffff_fffc, 32'hffff_fffc, 1'b1, 1'b1, 32'hbfc0_010c};
        vecs[14] = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1'b1, 32'hffff_fffc};
        vecs[15] = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'h0000_0004, 1'b1, 1'b1, 32'h0000_0000};
        vecs[16] = '{1'b0, 6'b000000, 1'b0, 32'h0,         32'h0000_0008, 1'b1, 1'b1, 32'h0000_0004};
        vecs[17] = '{1'b0, 6'b000111, 1'b0, 32'h0,         32'h0000_0008, 1'b1, 1'b1, 32'h0000_0004};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br_e, vecs[i].br_addr);
            check_outs(i, vecs[i].exp_pc, vecs[i].exp_ce, vecs[i].chk_inst, vecs[i].exp_inst);
        end
        check("wen", {28'h0, bus.inst_sram_wen}, 32'h0);
        check("wdata", bus.inst_sram_wdata, 32'h0);

        // Long hold: still in HELD on word 4, keep stalling a few more cycles.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 6'b000111, 1'b0, 32'h0);
            check_outs(100 + k, 32'h0000_0008, 1'b1, 1'b1, 32'h0000_0004);
        end
        check("hold_cap", dut.hold_reg, 32'h0000_0004);

        // Reset while HELD: everything back to reset values.
        drive(1'b1, 6'b000111, 1'b0, 32'h0);
        check_outs(200, 32'hbfbf_fffc, 1'b0, 1'b1, 32'h0);
        check("hold_rst", dut.hold_reg, 32'h0);

        // Fetch restarts at RESET_PC, word follows one cycle later.
        drive(1'b0, 6'b000000, 1'b0, 32'h0);
        check_outs(201, 32'hbfc0_0000, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 6'b000000, 1'b0, 32'h0);
        check_outs(202, 32'hbfc0_0004, 1'b1, 1'b1, 32'hbfc0_0000);
        drive(1'b0, 6'b000000, 1'b0, 32'h0);
        check_outs(203, 32'hbfc0_0008, 1'b1, 1'b1, 32'hbfc0_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
